// File: rtl/uart_pkg.sv
// Shared constants, banner contents and state encodings for the serial console path.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int BANNER_LEN = 4;
    // Element 0 is sent first: "OK\r\n".
    localparam logic [BANNER_LEN-1:0][7:0] BANNER = {8'h0A, 8'h0D, 8'h4B, 8'h4F};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic logic [7:0] banner_byte(input logic [1:0] idx);
        return BANNER[idx];
    endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-wide valid/ready stream between a byte producer and a serial transmitter.
interface uart_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; accepts a byte via valid/ready and drives a registered line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
    input  logic  clock,
    input  logic  reset,
    uart_if.slave in_stream,
    output logic  io_tx
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;

    assign bit_done = (cnt == BIT_LAST);
    // Ready in the last stop-bit cycle lets the next frame follow with no idle gap.
    assign in_stream.ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_done);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            io_tx   <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    cnt   <= '0;
                    io_tx <= 1'b1;
                    if (in_stream.valid) begin
                        shreg <= in_stream.data;
                        io_tx <= 1'b0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        io_tx   <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            io_tx <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            io_tx   <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (in_stream.valid) begin
                            shreg <= in_stream.data;
                            io_tx <= 1'b0;
                            state <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_top.sv
// Serial console top: sends a banner after reset, then echoes every well-framed received byte.
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
)(
    input  logic clock,
    input  logic reset,
    input  logic io_rx,
    output logic io_tx
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [1:0]       rx_sync;
    logic             rx_bit;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_idx;
    logic [7:0]       rx_shreg;
    logic [7:0]       rx_data;
    logic             rx_valid;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic [2:0]       banner_idx;
    logic             banner_active;
    logic             tx_fire;

    uart_if tx_stream ();

    // Sync flops reset high so a line that is undriven at power-up looks idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], io_rx};
    end
    assign rx_bit = rx_sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shreg   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_bit == 1'b0) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= (rx_bit == 1'b0) ? RX_DATA : RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_shreg   <= {rx_bit, rx_shreg[7:1]};
                        rx_bit_idx <= rx_bit_idx + 1'b1;
                        if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_bit == 1'b1) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shreg;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_pop   = tx_fire && !banner_active;
    assign fifo_push  = rx_valid && (!fifo_full || fifo_pop);

    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign banner_active   = (banner_idx < 3'(BANNER_LEN));
    assign tx_stream.valid = banner_active || !fifo_empty;
    assign tx_stream.data  = banner_active ? banner_byte(banner_idx[1:0]) : fifo_mem[rd_ptr];
    assign tx_fire         = tx_stream.valid && tx_stream.ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       banner_idx <= '0;
        else if (tx_fire && banner_active) banner_idx <= banner_idx + 3'd1;
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock     (clock),
        .reset     (reset),
        .in_stream (tx_stream),
        .io_tx     (io_tx)
    );

endmodule

// File: tb/tb_uart_echo_top.sv
// Scoreboard bench for uart_echo_top: serial frames on io_tx are decoded and matched against queued expectations.
module tb_uart_echo_top;

    localparam int CPB = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rx_drive_en = 1'b1;
    logic rx_val = 1'b1;
    wire  io_rx;
    logic io_tx;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   frame_start = 0;
    bit   in_frame = 1'b0;
    time  last_rise = 0;
    logic [7:0] exp_q [$];
    logic [7:0] banner_exp [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

    assign io_rx = rx_drive_en ? rx_val : 1'bz;

    uart_if mon_bus ();

    uart_echo_top #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .io_rx (io_rx),
        .io_tx (io_tx)
    );

    always #1 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;
    always @(posedge io_tx) last_rise = $time;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame; callers are aligned to a falling clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input bit expect_echo);
        logic [9:0] bits;
        if (expect_echo) exp_q.push_back(data);
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_val = bits[b];
            repeat (CPB) @(negedge clock);
        end
        rx_val = 1'b1;
    endtask

    task automatic release_reset();
        int k;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(banner_exp[i]);
        k = 0;
        while (io_tx !== 1'b0 && k < 4) begin
            @(negedge clock);
            k++;
        end
        checkOutput("banner_start_latency_ok", int'(k >= 1 && k <= 2), 1);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clock);
            k++;
        end
        checkOutput(name, exp_q.size(), 0);
        repeat (20) @(negedge clock);
    endtask

    // Decoder: samples every cycle of a frame so a stretched or corrupted bit is caught.
    initial begin : decoder
        logic [9:0] bits;
        bit aborted;
        bit shape_ok;
        mon_bus.valid = 1'b0;
        mon_bus.data  = '0;
        forever begin
            @(negedge clock);
            mon_bus.valid = 1'b0;
            if (reset === 1'b1 && io_tx === 1'b0) begin
                in_frame    = 1'b1;
                frame_start = cycle;
                aborted     = 1'b0;
                shape_ok    = 1'b1;
                bits        = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < CPB; s++) begin
                        if (b != 0 || s != 0) @(negedge clock);
                        if (reset !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (s == 0) bits[b] = io_tx;
                        else if (io_tx !== bits[b]) shape_ok = 1'b0;
                    end
                    if (aborted) break;
                end
                in_frame = 1'b0;
                if (!aborted) begin
                    checkOutput("frame_shape", int'(shape_ok && bits[0] == 1'b0 && bits[9] == 1'b1), 1);
                    mon_bus.data  = bits[8:1];
                    mon_bus.valid = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        logic [7:0] exp_b;
        forever begin
            @(posedge clock);
            if (mon_bus.valid && mon_bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_frame: got 0x%02h, required no frame", mon_bus.data);
                end else begin
                    exp_b = exp_q.pop_front();
                    checkOutput("tx_byte", int'(mon_bus.data), int'(exp_b));
                end
            end
        end
    end

    initial begin : main
        int k;
        time reset_t;
        mon_bus.ready = 1'b1;

        $display("[TB] banner after reset");
        repeat (5) @(negedge clock);
        checkOutput("tx_idle_in_reset", int'(io_tx), 1);
        release_reset();
        wait_drain("banner_drained", 400);

        $display("[TB] simple echo");
        applyStimulus(8'h55, 1'b1, 1'b1);
        wait_drain("echo_55_drained", 200);

        $display("[TB] streaming echo");
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        applyStimulus(8'hA5, 1'b1, 1'b1);
        wait_drain("stream_drained", 300);

        $display("[TB] glitch and framing error");
        rx_val = 1'b0;
        repeat (3) @(negedge clock);
        rx_val = 1'b1;
        repeat (30) @(negedge clock);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        repeat (30) @(negedge clock);
        applyStimulus(8'h12, 1'b1, 1'b1);
        wait_drain("noise_drained", 300);

        $display("[TB] reset during echo");
        applyStimulus(8'hA9, 1'b1, 1'b1);
        k = 0;
        while (!in_frame && k < 200) begin
            @(negedge clock);
            k++;
        end
        checkOutput("echo_started", int'(in_frame), 1);
        k = 0;
        while (cycle < frame_start + 28 && k < 200) begin
            @(negedge clock);
            k++;
        end
        reset_t = $time;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        checkOutput("tx_high_at_reset_assert", int'(last_rise), int'(reset_t));
        checkOutput("tx_idle_mid_reset", int'(io_tx), 1);
        repeat (4) @(negedge clock);
        release_reset();
        wait_drain("banner_restart_drained", 400);
        repeat (200) @(negedge clock);

        $display("[TB] undriven rx line");
        reset = 1'b0;
        rx_drive_en = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("tx_idle_in_reset_z", int'(io_tx), 1);
        release_reset();
        repeat (5000) @(negedge clock);
        wait_drain("z_banner_only", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_echo_top.md
Name: uart_echo_top

Overview:
- FPGA top level for the serial console path.
- After every reset it transmits a fixed 4-byte banner on io_tx, then echoes each correctly framed byte received on io_rx back out on io_tx.
- UART format is 8N1, LSB first, at a fixed clocks-per-bit rate.
- A small FIFO decouples the receiver from the transmitter.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be at least 4.
- FIFO_DEPTH, 16, echo FIFO entries; must be a power of two, at least 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_rx  input  1  UART receive line; idles high; asynchronous to clock.
- io_tx  output 1  UART transmit line; idles high.

Behaviour:
- Reset: while reset=0, io_tx=1.
  - Synchronizer flops reset to 1.
  - FIFO is emptied.
  - Banner index goes to 0.
  - RX and TX state machines return to IDLE.
- Reset asserted mid-frame aborts the frame; io_tx goes to 1 asynchronously.
- RX input: io_rx passes through a 2-flop synchronizer. A start is recognised only when the synchronized value equals 0, so X/Z or an undriven line never starts a frame.
- RX FSM:
  - IDLE -> START on synchronized 0.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits, each CLKS_PER_BIT cycles apart (mid-bit), LSB first.
  - STOP: sample once more. If 1, pulse rx_valid for one cycle with the byte. If 0, it is a framing error: discard the byte.
  - RX then returns to IDLE.
- FIFO: a write happens on rx_valid. If the FIFO is full, the byte is dropped and FIFO contents are unchanged. A simultaneous push and pop on a full FIFO is allowed and keeps the count.
- TX FSM:
  - IDLE: io_tx=1.
  - START: io_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: io_tx=1 for CLKS_PER_BIT cycles.
  - After STOP, TX returns to IDLE and may load the next byte in the same cycle, so back-to-back frames have no idle gap.
- TX source select:
  - While banner index < 4, TX sends banner bytes 0x4F, 0x4B, 0x0D, 0x0A ("OK\r\n") in order.
  - After the banner, TX pops the FIFO whenever it is non-empty.
  - RX runs and fills the FIFO while the banner is still being sent.
- Latency:
  - First banner start bit appears on io_tx no later than 2 clocks after reset deasserts.
  - An echo start bit appears no later than 3 clocks after the RX stop-bit sample, provided TX is idle and the banner is done.
- io_tx is driven from a register (glitch-free).

Decomposition:
- Package uart_pkg holds:
  - the default CLKS_PER_BIT;
  - the banner byte array and its length (4);
  - the RX and TX state enums (IDLE, START, DATA, STOP).
- Natural sub-module: uart_tx (byte in, valid/ready handshake, serial out).
- RX, FIFO and banner sequencer stay inline in uart_echo_top.

Test Plan (all with CLKS_PER_BIT=8, 2 ns clock):
1. Banner: pulse reset low with io_rx=1, then release. io_tx must be 1 during reset, then show 4 frames of 80 clocks each decoding to 0x4F, 0x4B, 0x0D, 0x0A, then stay 1.
2. Simple echo: after the banner, send 0x55 on io_rx. io_tx must carry one frame decoding to 0x55.
3. Streaming: send 0x00, 0xFF, 0xA5 back-to-back. io_tx must echo them in that order, each frame exactly 80 clocks, with no corrupted bits.
4. Noise and framing:
   - io_rx low for 3 clocks: no output.
   - 0x3C with stop bit 0: no output.
   - A following valid 0x12: echoed as 0x12.
5. Reset mid-operation: assert reset during the 3rd data bit of an echo. io_tx must go to 1 immediately; after release the banner restarts from 0x4F, and the aborted byte is not resent.
6. Undriven io_rx (Z) for 5000 clocks after reset: only the banner appears on io_tx, with no spurious echoes.
